// File: rtl/alu_op_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_op_driver
//
// Command-side sequencer for a small combinational ALU. Accepts one request
// (sel, A, B) over a valid/ready handshake, drives the ALU inputs from
// registers, waits SETTLE cycles for the ALU output to settle, captures X and
// returns it over a second valid/ready handshake. Only one operation is in
// flight at a time.
//
// Optional feature: define ALU_CHECK_EN to compare each captured X against the
// expected value supplied with the command (rsp_err, saturating err_cnt).
// Without it cmd_exp is ignored and rsp_err/err_cnt are constant 0.
//
// Parameters:
//   WIDTH   operand/result width
//   SEL_W   ALU select width
//   SETTLE  cycles from driving operands to capturing X (legal 1..15)
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready       request handshake
//   cmd_sel/cmd_a/cmd_b       requested operation and operands
//   cmd_exp                   expected result (checker only)
//   alu_sel/alu_a/alu_b       registered drive to the ALU (held after use)
//   alu_x                     ALU result
//   rsp_valid/rsp_ready       response handshake
//   rsp_x/rsp_sel             captured result and the select that produced it
//   rsp_err                   captured result differed from cmd_exp
//   err_cnt                   saturating mismatch count, cleared only by rst
//   busy                      high in any state except IDLE
// -----------------------------------------------------------------------------
module alu_op_driver #(
    parameter int WIDTH  = 6,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_exp,
    output logic [SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_x,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_x,
    output logic [SEL_W-1:0] rsp_sel,
    output logic             rsp_err,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    // Out-of-range SETTLE values are clamped into the 4-bit counter's 1..15.
    localparam int SETTLE_CLAMP = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_CLAMP);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [SEL_W-1:0] alu_sel_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [WIDTH-1:0] rsp_x_q;
    logic [SEL_W-1:0] rsp_sel_q;

    logic accept;
    logic capture;

    // Handshake outputs depend on registered state only, so there is no
    // combinational path from cmd_valid or rsp_ready.
    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

    assign accept  = (state_q == ST_IDLE) && cmd_valid;
    // The counter was loaded with SETTLE on the accept edge, so reaching 1
    // here lands the capture exactly SETTLE edges after accept.
    assign capture = (state_q == ST_SETTLE) && (cnt_q == 4'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            alu_sel_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            rsp_x_q   <= '0;
            rsp_sel_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        alu_sel_q <= cmd_sel;
                        alu_a_q   <= cmd_a;
                        alu_b_q   <= cmd_b;
                        cnt_q     <= SETTLE_CNT;
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (capture) begin
                        rsp_x_q   <= alu_x;
                        rsp_sel_q <= alu_sel_q;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_sel = alu_sel_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign rsp_x   = rsp_x_q;
    assign rsp_sel = rsp_sel_q;

`ifdef ALU_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             rsp_err_q;
    logic [7:0]       err_cnt_q;
    logic             mismatch;
    logic [7:0]       err_cnt_d;

    assign mismatch = (alu_x != exp_q);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (capture && mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // NOTE: exp_q carries no reset; it is always written on accept before the
    // capture that reads it, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            exp_q <= cmd_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (capture) begin
                rsp_err_q <= mismatch;
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rsp_err = rsp_err_q;
    assign err_cnt = err_cnt_q;
`else
    // Checker not built: the expected value is deliberately discarded.
    logic unused_cmd_exp;
    assign unused_cmd_exp = ^cmd_exp;

    assign rsp_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
`timescale 1ns/1ps
// Self-checking bench for alu_op_driver.
//   dut    : SETTLE=1 against an ideal combinational ALU model
//   dut_s3 : SETTLE=3 against an ALU model with 2-cycle output delay
//   dut_s1d: SETTLE=1 against the same delayed ALU model (returns stale X)
module tb_alu_op_driver;

    localparam int W = 6;
    localparam int S = 4;

`ifdef ALU_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference ALU behaviour (arbitrary but fixed operation table).
    function automatic logic [W-1:0] alu_fn(input logic [S-1:0] sel,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return b;
            4'd9:    return ~(a & b);
            default: return a + b + W'(sel);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- main DUT (ideal ALU) ----------------
    logic         m_cmd_valid = 1'b0, m_cmd_ready, m_rsp_valid, m_rsp_ready = 1'b0;
    logic [S-1:0] m_cmd_sel = '0, m_alu_sel, m_rsp_sel;
    logic [W-1:0] m_cmd_a = '0, m_cmd_b = '0, m_cmd_exp = '0;
    logic [W-1:0] m_alu_a, m_alu_b, m_alu_x, m_rsp_x;
    logic         m_rsp_err, m_busy;
    logic [7:0]   m_err_cnt;

    assign m_alu_x = alu_fn(m_alu_sel, m_alu_a, m_alu_b);

    alu_op_driver #(.WIDTH(W), .SEL_W(S), .SETTLE(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(m_cmd_valid), .cmd_ready(m_cmd_ready),
        .cmd_sel(m_cmd_sel), .cmd_a(m_cmd_a), .cmd_b(m_cmd_b), .cmd_exp(m_cmd_exp),
        .alu_sel(m_alu_sel), .alu_a(m_alu_a), .alu_b(m_alu_b), .alu_x(m_alu_x),
        .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready),
        .rsp_x(m_rsp_x), .rsp_sel(m_rsp_sel), .rsp_err(m_rsp_err),
        .err_cnt(m_err_cnt), .busy(m_busy)
    );

    // ---------------- settle group (delayed ALU) ----------------
    logic         g_cmd_valid = 1'b0, g_rsp_ready = 1'b1;
    logic [S-1:0] g_cmd_sel = '0;
    logic [W-1:0] g_cmd_a = '0, g_cmd_b = '0, g_cmd_exp = '0;

    logic         t_cmd_ready, t_rsp_valid, t_rsp_err, t_busy;
    logic [S-1:0] t_alu_sel, t_rsp_sel;
    logic [W-1:0] t_alu_a, t_alu_b, t_rsp_x;
    logic [W-1:0] t_x1 = '0, t_x2 = '0;
    logic [7:0]   t_err_cnt;

    logic         u_cmd_ready, u_rsp_valid, u_rsp_err, u_busy;
    logic [S-1:0] u_alu_sel, u_rsp_sel;
    logic [W-1:0] u_alu_a, u_alu_b, u_rsp_x;
    logic [W-1:0] u_x1 = '0, u_x2 = '0;
    logic [7:0]   u_err_cnt;

    // Two-cycle output delay: X reflects operands from two edges earlier.
    always @(posedge clk) begin
        t_x1 <= alu_fn(t_alu_sel, t_alu_a, t_alu_b);
        t_x2 <= t_x1;
        u_x1 <= alu_fn(u_alu_sel, u_alu_a, u_alu_b);
        u_x2 <= u_x1;
    end

    alu_op_driver #(.WIDTH(W), .SEL_W(S), .SETTLE(3)) dut_s3 (
        .clk(clk), .rst(rst),
        .cmd_valid(g_cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_sel(g_cmd_sel), .cmd_a(g_cmd_a), .cmd_b(g_cmd_b), .cmd_exp(g_cmd_exp),
        .alu_sel(t_alu_sel), .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_x(t_x2),
        .rsp_valid(t_rsp_valid), .rsp_ready(g_rsp_ready),
        .rsp_x(t_rsp_x), .rsp_sel(t_rsp_sel), .rsp_err(t_rsp_err),
        .err_cnt(t_err_cnt), .busy(t_busy)
    );

    alu_op_driver #(.WIDTH(W), .SEL_W(S), .SETTLE(1)) dut_s1d (
        .clk(clk), .rst(rst),
        .cmd_valid(g_cmd_valid), .cmd_ready(u_cmd_ready),
        .cmd_sel(g_cmd_sel), .cmd_a(g_cmd_a), .cmd_b(g_cmd_b), .cmd_exp(g_cmd_exp),
        .alu_sel(u_alu_sel), .alu_a(u_alu_a), .alu_b(u_alu_b), .alu_x(u_x2),
        .rsp_valid(u_rsp_valid), .rsp_ready(g_rsp_ready),
        .rsp_x(u_rsp_x), .rsp_sel(u_rsp_sel), .rsp_err(u_rsp_err),
        .err_cnt(u_err_cnt), .busy(u_busy)
    );

    // ---------------- reference-model state ----------------
    int           model_errs = 0;
    logic [S-1:0] prev_sel = '0;
    logic [W-1:0] prev_a = '0, prev_b = '0;

    function automatic logic [7:0] exp_err_cnt();
        if (!CHK) return 8'd0;
        return (model_errs > 255) ? 8'd255 : 8'(model_errs);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full operation on the main DUT with rsp_ready already high.
    task automatic main_op(input logic [S-1:0] sel, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] e,
                           input string tag);
        logic [W-1:0] x;
        logic         mis;
        x   = alu_fn(sel, a, b);
        mis = CHK && (x != e);
        m_cmd_sel = sel; m_cmd_a = a; m_cmd_b = b; m_cmd_exp = e;
        m_cmd_valid = 1'b1; m_rsp_ready = 1'b1;
        tick();                                   // accept edge E
        m_cmd_valid = 1'b0;
        m_cmd_a = ~a; m_cmd_b = ~b; m_cmd_sel = ~sel;
        check({tag, "/alu_a"},     32'(m_alu_a), 32'(a));
        check({tag, "/alu_b"},     32'(m_alu_b), 32'(b));
        check({tag, "/alu_sel"},   32'(m_alu_sel), 32'(sel));
        check({tag, "/busy"},      32'(m_busy), 32'd1);
        check({tag, "/cmd_ready0"},32'(m_cmd_ready), 32'd0);
        check({tag, "/rsp_early"}, 32'(m_rsp_valid), 32'd0);
        tick();                                   // capture edge E+1
        if (mis) model_errs++;
        check({tag, "/rsp_valid"}, 32'(m_rsp_valid), 32'd1);
        check({tag, "/rsp_x"},     32'(m_rsp_x), 32'(x));
        check({tag, "/rsp_sel"},   32'(m_rsp_sel), 32'(sel));
        check({tag, "/rsp_err"},   32'(m_rsp_err), 32'(mis));
        check({tag, "/err_cnt"},   32'(m_err_cnt), 32'(exp_err_cnt()));
        tick();                                   // handshake edge E+2
        check({tag, "/rsp_done"},  32'(m_rsp_valid), 32'd0);
        check({tag, "/cmd_ready1"},32'(m_cmd_ready), 32'd1);
        check({tag, "/alu_hold"},  32'(m_alu_a), 32'(a));
    endtask

    // One operation issued to both delayed-ALU instances on the same edge.
    task automatic grp_op(input logic [S-1:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input string tag);
        logic [W-1:0] x_new, x_old;
        x_new = alu_fn(sel, a, b);
        x_old = alu_fn(prev_sel, prev_a, prev_b);
        check({tag, "/both_ready"}, 32'(t_cmd_ready & u_cmd_ready), 32'd1);
        g_cmd_sel = sel; g_cmd_a = a; g_cmd_b = b;
        g_cmd_valid = 1'b1; g_rsp_ready = 1'b1;
        tick();                                   // E
        g_cmd_valid = 1'b0;
        check({tag, "/s3_alu_a"},   32'(t_alu_a), 32'(a));
        tick();                                   // E+1
        check({tag, "/s1_valid"},   32'(u_rsp_valid), 32'd1);
        check({tag, "/s1_stale_x"}, 32'(u_rsp_x), 32'(x_old));
        check({tag, "/s3_wait1"},   32'(t_rsp_valid), 32'd0);
        tick();                                   // E+2
        check({tag, "/s3_wait2"},   32'(t_rsp_valid), 32'd0);
        tick();                                   // E+3
        check({tag, "/s3_valid"},   32'(t_rsp_valid), 32'd1);
        check({tag, "/s3_x"},       32'(t_rsp_x), 32'(x_new));
        check({tag, "/s3_sel"},     32'(t_rsp_sel), 32'(sel));
        tick();                                   // E+4
        check({tag, "/s3_ready"},   32'(t_cmd_ready), 32'd1);
        prev_sel = sel; prev_a = a; prev_b = b;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [S-1:0] rs;
        logic [W-1:0] ra, rb, re, bx;

        // ---- reset with cmd_valid held high ----
        rst = 1'b1;
        m_cmd_valid = 1'b1; m_cmd_sel = 4'd3; m_cmd_a = 6'h2A; m_cmd_b = 6'h15;
        g_cmd_valid = 1'b1; g_cmd_a = 6'h11;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst/busy",      32'(m_busy), 32'd0);
            check("rst/rsp_valid", 32'(m_rsp_valid), 32'd0);
            check("rst/alu_sel",   32'(m_alu_sel), 32'd0);
            check("rst/alu_a",     32'(m_alu_a), 32'd0);
            check("rst/alu_b",     32'(m_alu_b), 32'd0);
            check("rst/rsp_x",     32'(m_rsp_x), 32'd0);
            check("rst/rsp_sel",   32'(m_rsp_sel), 32'd0);
            check("rst/rsp_err",   32'(m_rsp_err), 32'd0);
            check("rst/err_cnt",   32'(m_err_cnt), 32'd0);
            check("rst/s3_busy",   32'(t_busy), 32'd0);
        end
        m_cmd_valid = 1'b0; g_cmd_valid = 1'b0; rst = 1'b0;
        tick();
        check("rst/cmd_ready", 32'(m_cmd_ready), 32'd1);
        check("rst/no_accept", 32'(m_alu_a), 32'd0);
        repeat (3) tick();

        // ---- basic op ----
        main_op(4'b0011, 6'b000100, 6'b000010, alu_fn(4'b0011, 6'b000100, 6'b000010), "basic");

        // ---- randomized ops, expected value right or wrong ----
        for (int i = 0; i < 24; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = 6'($urandom);
            rb = 6'($urandom);
            re = ($urandom_range(0, 1) == 0) ? alu_fn(rs, ra, rb) : 6'($urandom);
            main_op(rs, ra, rb, re, "rand");
        end

        // ---- checker: match leaves count, mismatch increments ----
        main_op(4'd4, 6'h0F, 6'h33, alu_fn(4'd4, 6'h0F, 6'h33), "chk_match");
        main_op(4'd4, 6'h0F, 6'h33, ~alu_fn(4'd4, 6'h0F, 6'h33), "chk_miss");

        // ---- backpressure ----
        rs = 4'($urandom_range(0, 15));
        bx = alu_fn(rs, 6'h3F, 6'h3F);
        m_cmd_sel = rs; m_cmd_a = 6'h3F; m_cmd_b = 6'h3F; m_cmd_exp = bx;
        m_cmd_valid = 1'b1; m_rsp_ready = 1'b0;
        tick();
        check("bp/alu_a", 32'(m_alu_a), 32'h3F);
        m_cmd_sel = 4'd2; m_cmd_a = 6'h05; m_cmd_b = 6'h09;   // second request, held
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp/rsp_valid", 32'(m_rsp_valid), 32'd1);
            check("bp/rsp_x",     32'(m_rsp_x), 32'(bx));
            check("bp/rsp_sel",   32'(m_rsp_sel), 32'(rs));
            check("bp/cmd_ready", 32'(m_cmd_ready), 32'd0);
            tick();
        end
        m_cmd_valid = 1'b0; m_rsp_ready = 1'b1;
        tick();
        check("bp/released",  32'(m_rsp_valid), 32'd0);
        check("bp/cmd_ready", 32'(m_cmd_ready), 32'd1);
        check("bp/not_taken_a", 32'(m_alu_a), 32'h3F);
        check("bp/not_taken_b", 32'(m_alu_b), 32'h3F);

        // ---- 300 mismatches saturate the counter ----
        for (int i = 0; i < 300; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = 6'($urandom);
            rb = 6'($urandom);
            main_op(rs, ra, rb, ~alu_fn(rs, ra, rb), "sat");
        end
        check("sat/err_cnt_final", 32'(m_err_cnt), CHK ? 32'd255 : 32'd0);

        // ---- settle sweep ----
        grp_op(4'd0, 6'h05, 6'h07, "settle_a");
        grp_op(4'd4, 6'h2A, 6'h15, "settle_b");
        for (int i = 0; i < 6; i++) begin
            grp_op(4'($urandom_range(0, 15)), 6'($urandom), 6'($urandom), "settle_r");
        end

        // ---- abort: reset during SETTLE ----
        m_cmd_sel = 4'd1; m_cmd_a = 6'h10; m_cmd_b = 6'h03; m_cmd_valid = 1'b1; m_rsp_ready = 1'b1;
        tick();
        m_cmd_valid = 1'b0;
        check("abort/busy_before", 32'(m_busy), 32'd1);
        rst = 1'b1;
        tick();
        model_errs = 0;
        prev_sel = '0; prev_a = '0; prev_b = '0;
        check("abort/rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("abort/busy",      32'(m_busy), 32'd0);
        check("abort/cmd_ready", 32'(m_cmd_ready), 32'd1);
        check("abort/alu_a",     32'(m_alu_a), 32'd0);
        check("abort/alu_sel",   32'(m_alu_sel), 32'd0);
        check("abort/err_cnt",   32'(m_err_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort/no_rsp", 32'(m_rsp_valid), 32'd0);
        end
        main_op(4'd7, 6'h3C, 6'h01, 6'h00, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
